// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a transmit FIFO and an internal baud divider.
//
// Words enter through a valid/ready port and are queued in the FIFO. They are then sent
// LSB first as: start bit, 5..DATA_W data bits, an optional parity bit, and one or two
// stop bits. Word length, parity, stop bits and the baud divisor are captured when a word
// is popped, so changing them mid-frame only affects later frames. Frames go out
// back-to-back with no idle bit while the FIFO still holds data.
//
// Optional feature (define UART_TX_BREAK_EN): adds break_req_i. While break_req_i is high,
// the line is held low (break). A break starts from idle, or after the frame in progress
// has finished. When break_req_i drops, the line is held high for one bit time before the
// next start bit can begin.
//
// Ports:
//   clk_i             system clock, rising edge
//   rst_ni            synchronous active-low reset
//   baud_div_i        bit period = baud_div_i+1 clocks (0 behaves as 1)
//   cfg_length_i      data bits per frame, clamped to 5..DATA_W
//   cfg_parity_en_i   insert a parity bit
//   cfg_parity_type_i 1 = even parity, 0 = odd parity
//   cfg_stop2_i       two stop bits
//   break_req_i       break request (UART_TX_BREAK_EN only)
//   in_valid_i/in_data_i/in_ready_o  write port; in_ready_o = FIFO not full
//   tx_o              serial line (registered)
//   tx_busy_o         high from the start bit through the last stop bit
//   tx_done_o         pulse on the final clock of the last stop bit
//   tx_err_o          pulse after a write attempted while the FIFO was full
//   fifo_level_o      number of entries held
module uart_tx_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16,
  localparam int unsigned LvlW      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DIV_W-1:0]  baud_div_i,
  input  logic [3:0]        cfg_length_i,
  input  logic              cfg_parity_en_i,
  input  logic              cfg_parity_type_i,
  input  logic              cfg_stop2_i,
`ifdef UART_TX_BREAK_EN
  input  logic              break_req_i,
`endif
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              tx_o,
  output logic              tx_busy_o,
  output logic              tx_done_o,
  output logic              tx_err_o,
  output logic [LvlW-1:0]   fifo_level_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop1, StStop2, StBreak, StGap
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q;
  logic              tx_err_q;
  logic              full, empty, push, pop;
  logic [DATA_W-1:0] head;

  assign full       = (level_q == LvlW'(FIFO_DEPTH));
  assign empty      = (level_q == '0);
  assign push       = in_valid_i && !full;
  assign head       = mem_q[rd_ptr_q];
  assign in_ready_o = !full;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      tx_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LvlW'(1);
        2'b01:   level_q <= level_q - LvlW'(1);
        default: level_q <= level_q;
      endcase
      tx_err_q <= in_valid_i && full;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_e            state_q;
  logic [DIV_W-1:0]  cnt_q, div_q;
  logic [3:0]        len_q, bit_idx_q;
  logic              par_en_q, par_bit_q, stop2_q, tx_q;
  logic [DATA_W-1:0] shreg_q;

  logic [3:0]        len_eff;
  logic [DIV_W-1:0]  div_eff;
  logic [DATA_W-1:0] mask;
  logic              bit_end, frame_end, brk_req, brk_go;

`ifdef UART_TX_BREAK_EN
  assign brk_req = break_req_i;
`else
  assign brk_req = 1'b0;
`endif

  always_comb begin
    if (cfg_length_i < 4'd5)               len_eff = 4'd5;
    else if (cfg_length_i > 4'(DATA_W))    len_eff = 4'(DATA_W);
    else                                   len_eff = cfg_length_i;
  end

  assign div_eff = (baud_div_i == '0) ? DIV_W'(1) : baud_div_i;

  // Parity covers only the bits that will actually be sent.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < DATA_W; i++) mask[i] = (i < 32'(len_eff));
  end

  assign bit_end   = (cnt_q == '0);
  assign frame_end = bit_end &&
                     ((state_q == StStop1 && !stop2_q) || state_q == StStop2);
  // A new frame (or a break) may start from idle, or directly at the end of the last stop bit.
  assign brk_go    = brk_req && (state_q == StIdle || frame_end);
  assign pop       = !empty && !brk_req && (state_q == StIdle || frame_end);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      div_q     <= '0;
      len_q     <= 4'd5;
      bit_idx_q <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
    end else if (pop) begin
      state_q   <= StStart;
      cnt_q     <= div_eff;
      div_q     <= div_eff;
      len_q     <= len_eff;
      par_en_q  <= cfg_parity_en_i;
      par_bit_q <= cfg_parity_type_i ? ^(head & mask) : ~^(head & mask);
      stop2_q   <= cfg_stop2_i;
      shreg_q   <= head;
      tx_q      <= 1'b0;
    end else if (brk_go) begin
      state_q <= StBreak;
      tx_q    <= 1'b0;
    end else begin
      // Generic bit timer; individual states override the reload where needed.
      if (state_q != StIdle) cnt_q <= bit_end ? div_q : cnt_q - DIV_W'(1);
      case (state_q)
        StStart: begin
          if (bit_end) begin
            state_q   <= StData;
            tx_q      <= shreg_q[0];
            bit_idx_q <= '0;
          end
        end
        StData: begin
          if (bit_end) begin
            if (bit_idx_q == len_q - 4'd1) begin
              state_q <= par_en_q ? StParity : StStop1;
              tx_q    <= par_en_q ? par_bit_q : 1'b1;
            end else begin
              shreg_q   <= shreg_q >> 1;
              tx_q      <= shreg_q[1];
              bit_idx_q <= bit_idx_q + 4'd1;
            end
          end
        end
        StParity: begin
          if (bit_end) begin
            state_q <= StStop1;
            tx_q    <= 1'b1;
          end
        end
        StStop1: begin
          if (bit_end) state_q <= stop2_q ? StStop2 : StIdle;
        end
        StStop2: begin
          if (bit_end) state_q <= StIdle;
        end
`ifdef UART_TX_BREAK_EN
        StBreak: begin
          if (!brk_req) begin
            // Guarantee one full high bit before any following start bit.
            state_q <= StGap;
            cnt_q   <= div_eff;
            div_q   <= div_eff;
            tx_q    <= 1'b1;
          end
        end
        StGap: begin
          if (bit_end) state_q <= StIdle;
        end
`endif
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx_o         = tx_q;
  assign tx_busy_o    = (state_q != StIdle);
  assign tx_done_o    = frame_end;
  assign tx_err_o     = tx_err_q;
  assign fifo_level_o = level_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo (default build, 8-bit data, 8-entry FIFO).
module tb_uart_tx_fifo;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned DIV_W      = 16;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [DIV_W-1:0]  baud_div_i = 16'd3;
  logic [3:0]        cfg_length_i = 4'd8;
  logic              cfg_parity_en_i = 1'b0;
  logic              cfg_parity_type_i = 1'b0;
  logic              cfg_stop2_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic [DATA_W-1:0] in_data_i = '0;
  logic              in_ready_o, tx_o, tx_busy_o, tx_done_o, tx_err_o;
  logic [3:0]        fifo_level_o;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .DIV_W     (DIV_W)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .baud_div_i       (baud_div_i),
    .cfg_length_i     (cfg_length_i),
    .cfg_parity_en_i  (cfg_parity_en_i),
    .cfg_parity_type_i(cfg_parity_type_i),
    .cfg_stop2_i      (cfg_stop2_i),
    .in_valid_i       (in_valid_i),
    .in_data_i        (in_data_i),
    .in_ready_o       (in_ready_o),
    .tx_o             (tx_o),
    .tx_busy_o        (tx_busy_o),
    .tx_done_o        (tx_done_o),
    .tx_err_o         (tx_err_o),
    .fifo_level_o     (fifo_level_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    checks++;
    if (tx_o !== 1'b1 || tx_busy_o !== 1'b0 || tx_done_o !== 1'b0 || tx_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs tx=%b busy=%b done=%b err=%b, want 1 0 0 0",
               tx_o, tx_busy_o, tx_done_o, tx_err_o);
    end
    checks++;
    if (fifo_level_o !== 4'd0 || in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_fifo level=%0d ready=%b, want 0 1", fifo_level_o, in_ready_o);
    end
    rst_ni = 1'b1;
    tick();
  endtask

  // 0xA5, 8N1, 4 clocks per bit.
  task automatic test_basic_frame();
    logic [0:15] exp;
    exp = 16'b0101001011_000000;
    baud_div_i = 16'd3; cfg_length_i = 4'd8; cfg_parity_en_i = 1'b0; cfg_stop2_i = 1'b0;
    in_valid_i = 1'b1; in_data_i = 8'hA5;
    tick();
    in_valid_i = 1'b0;
    checks++;
    if (fifo_level_o !== 4'd1 || tx_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_accept level=%0d tx=%b, want 1 1", fifo_level_o, tx_o);
    end
    tick();
    checks++;
    if (fifo_level_o !== 4'd0) begin
      errors++;
      $display("FAIL basic_pop level=%0d, want 0", fifo_level_o);
    end
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (tx_o !== exp[k/4] || tx_busy_o !== 1'b1 || tx_done_o !== (k == 39)) begin
        errors++;
        $display("FAIL basic_frame k=%0d tx=%b busy=%b done=%b, want %b 1 %b",
                 k, tx_o, tx_busy_o, tx_done_o, exp[k/4], (k == 39));
      end
      tick();
    end
    checks++;
    if (tx_o !== 1'b1 || tx_busy_o !== 1'b0 || tx_done_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle tx=%b busy=%b done=%b, want 1 0 0", tx_o, tx_busy_o, tx_done_o);
    end
  endtask

  // 0xB5 with length 7 (bit 7 ignored), 2 stop bits, even then odd parity, 2 clocks/bit.
  task automatic test_parity();
    logic [0:15] exp;
    for (int v = 0; v < 2; v++) begin
      exp = (v == 0) ? 16'b01010110011_00000 : 16'b01010110111_00000;
      baud_div_i = 16'd1; cfg_length_i = 4'd7; cfg_parity_en_i = 1'b1;
      cfg_parity_type_i = (v == 0); cfg_stop2_i = 1'b1;
      in_valid_i = 1'b1; in_data_i = 8'hB5;
      tick();
      in_valid_i = 1'b0;
      tick();
      for (int k = 0; k < 22; k++) begin
        checks++;
        if (tx_o !== exp[k/2] || tx_done_o !== (k == 21)) begin
          errors++;
          $display("FAIL parity v=%0d k=%0d tx=%b done=%b, want %b %b",
                   v, k, tx_o, tx_done_o, exp[k/2], (k == 21));
        end
        tick();
      end
      checks++;
      if (tx_o !== 1'b1 || tx_busy_o !== 1'b0) begin
        errors++;
        $display("FAIL parity_idle v=%0d tx=%b busy=%b, want 1 0", v, tx_o, tx_busy_o);
      end
    end
    cfg_parity_en_i = 1'b0; cfg_stop2_i = 1'b0;
  endtask

  // Fill the FIFO behind a running 5N1 frame, overflow it, then drain back-to-back.
  task automatic test_fifo_full();
    logic [4:0] words [8];
    logic [4:0] got;
    int         n;
    words = '{5'h11, 5'h0A, 5'h1F, 5'h00, 5'h15, 5'h03, 5'h1C, 5'h09};
    baud_div_i = 16'd3; cfg_length_i = 4'd5; cfg_parity_en_i = 1'b0; cfg_stop2_i = 1'b0;
    in_valid_i = 1'b1; in_data_i = 8'h07;
    tick();
    in_valid_i = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (in_ready_o !== 1'b1 || fifo_level_o !== 4'(i)) begin
        errors++;
        $display("FAIL fill_pre i=%0d ready=%b level=%0d, want 1 %0d", i, in_ready_o,
                 fifo_level_o, i);
      end
      in_valid_i = 1'b1; in_data_i = {3'b101, words[i]};
      tick();
    end
    checks++;
    if (in_ready_o !== 1'b0 || fifo_level_o !== 4'd8 || tx_err_o !== 1'b0) begin
      errors++;
      $display("FAIL full ready=%b level=%0d err=%b, want 0 8 0", in_ready_o, fifo_level_o,
               tx_err_o);
    end
    in_data_i = 8'h1E;
    tick();
    in_valid_i = 1'b0;
    checks++;
    if (tx_err_o !== 1'b1 || fifo_level_o !== 4'd8) begin
      errors++;
      $display("FAIL overflow err=%b level=%0d, want 1 8", tx_err_o, fifo_level_o);
    end
    tick();
    checks++;
    if (tx_err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse err=%b, want 0", tx_err_o);
    end
    n = 0;
    while (tx_done_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL first_done_timeout cycles=%0d, want <100", n);
    end
    tick();
    for (int f = 0; f < 8; f++) begin
      got = '0;
      for (int cf = 0; cf < 28; cf++) begin
        if (cf == 0) begin
          checks++;
          if (tx_o !== 1'b0 || tx_busy_o !== 1'b1 || fifo_level_o !== 4'(7 - f)) begin
            errors++;
            $display("FAIL b2b_start f=%0d tx=%b busy=%b level=%0d, want 0 1 %0d",
                     f, tx_o, tx_busy_o, fifo_level_o, 7 - f);
          end
        end
        if (cf >= 6 && cf <= 22 && (cf - 6) % 4 == 0) got[(cf-6)/4] = tx_o;
        if (cf == 27) begin
          checks++;
          if (tx_done_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done f=%0d done=%b, want 1", f, tx_done_o);
          end
        end
        tick();
      end
      checks++;
      if (got !== words[f]) begin
        errors++;
        $display("FAIL b2b_data f=%0d got=%h, want %h", f, got, words[f]);
      end
    end
    checks++;
    if (tx_o !== 1'b1 || tx_busy_o !== 1'b0 || fifo_level_o !== 4'd0) begin
      errors++;
      $display("FAIL drain_idle tx=%b busy=%b level=%0d, want 1 0 0", tx_o, tx_busy_o,
               fifo_level_o);
    end
  endtask

  // Divisor change mid-frame applies only to the following frame.
  task automatic test_baud_change();
    logic [0:15] ex, ey;
    logic        e;
    ex = 16'b0111100001_000000;
    ey = 16'b0001111001_000000;
    baud_div_i = 16'd3; cfg_length_i = 4'd8;
    in_valid_i = 1'b1; in_data_i = 8'h0F;
    tick();
    in_data_i = 8'h3C;
    tick();
    in_valid_i = 1'b0;
    for (int k = 0; k < 120; k++) begin
      if (k == 10) baud_div_i = 16'd7;
      e = (k < 40) ? ex[k/4] : ey[(k-40)/8];
      checks++;
      if (tx_o !== e || tx_busy_o !== 1'b1 || tx_done_o !== (k == 39 || k == 119)) begin
        errors++;
        $display("FAIL baud_change k=%0d tx=%b busy=%b done=%b, want %b 1 %b",
                 k, tx_o, tx_busy_o, tx_done_o, e, (k == 39 || k == 119));
      end
      tick();
    end
    checks++;
    if (tx_o !== 1'b1 || tx_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL baud_change_idle tx=%b busy=%b, want 1 0", tx_o, tx_busy_o);
    end
  endtask

  // baud_div=0 behaves as 1: 2 clocks per bit.
  task automatic test_div0();
    logic [0:15] exp;
    exp = 16'b0101010101_000000;
    baud_div_i = 16'd0; cfg_length_i = 4'd8;
    in_valid_i = 1'b1; in_data_i = 8'h55;
    tick();
    in_valid_i = 1'b0;
    tick();
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (tx_o !== exp[k/2] || tx_done_o !== (k == 19)) begin
        errors++;
        $display("FAIL div0 k=%0d tx=%b done=%b, want %b %b", k, tx_o, tx_done_o, exp[k/2],
                 (k == 19));
      end
      tick();
    end
    checks++;
    if (tx_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL div0_idle busy=%b, want 0", tx_busy_o);
    end
  endtask

  // Reset during the parity bit aborts the frame and flushes the queued word.
  task automatic test_reset_mid_frame();
    baud_div_i = 16'd3; cfg_length_i = 4'd7; cfg_parity_en_i = 1'b1;
    cfg_parity_type_i = 1'b1; cfg_stop2_i = 1'b1;
    in_valid_i = 1'b1; in_data_i = 8'hB5;
    tick();
    in_data_i = 8'h12;
    tick();
    in_valid_i = 1'b0;
    for (int k = 0; k < 33; k++) tick();
    checks++;
    if (tx_o !== 1'b0 || fifo_level_o !== 4'd1 || tx_busy_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset tx=%b level=%0d busy=%b, want 0 1 1", tx_o, fifo_level_o,
               tx_busy_o);
    end
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    checks++;
    if (tx_o !== 1'b1 || fifo_level_o !== 4'd0 || tx_busy_o !== 1'b0 || tx_done_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset tx=%b level=%0d busy=%b done=%b, want 1 0 0 0",
               tx_o, fifo_level_o, tx_busy_o, tx_done_o);
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if (tx_o !== 1'b1 || tx_busy_o !== 1'b0 || tx_done_o !== 1'b0) begin
        errors++;
        $display("FAIL post_reset k=%0d tx=%b busy=%b done=%b, want 1 0 0",
                 k, tx_o, tx_busy_o, tx_done_o);
      end
    end
    cfg_parity_en_i = 1'b0; cfg_stop2_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_fifo_full();
    test_baud_change();
    test_div0();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
